lsu_dmem_port: RTL and testbench

Load/store initiator between the core's memory stage and the `dmem` data memory. It accepts one load or store request per transaction over a valid/ready handshake, checks alignment, and drives `dmem`'s addr/memop/datain/we. For loads it waits out the synchronous read latency, captures `dataout`, and returns the result over a held response handshake. `dmem` rdclk and wrclk are both tied to `clk` at the top level.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/lsu_align_check.sv | 27 ++
 rtl/lsu_dmem_port.sv | 141 ++++++++++++++
 tb/tb_lsu_dmem_port.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for data-memory clients.
//   - memop encodings understood by dmem
//   - LSU FSM state encoding
//   - mem_access_fault(): legality/alignment rule common to every client
//     (range is checked by the caller, since depth is a per-instance parameter)
package mem_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_WR,
        ST_RESP
    } lsu_state_e;

    // memop[1:0] carries the access size for every legal encoding, so the
    // alignment rule can look at it alone once illegal encodings are rejected.
    function automatic logic mem_access_fault(input logic       we,
                                              input logic [2:0] memop,
                                              input logic [1:0] addr_lo,
                                              input logic       in_range);
        logic illegal;
        logic misaligned;
        if (we)
            illegal = !(memop inside {MEMOP_B, MEMOP_H, MEMOP_W});
        else
            illegal = !(memop inside {MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU});
        misaligned = ((memop[1:0] == 2'b01) && addr_lo[0]) ||
                     ((memop[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal || misaligned || !in_range;
    endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Combinational request legality check for the LSU.
//   we_i     : 1 = store, 0 = load
//   memop_i  : dmem memop encoding
//   addr_i   : byte address
//   fault_o  : request must not reach memory (misaligned, out of range,
//              or memop not legal for the direction)
module lsu_align_check
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 2048
) (
    input  logic              we_i,
    input  logic [2:0]        memop_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              fault_o
);

    // One extra bit so the limit is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * MEM_WORDS);

    logic in_range;

    assign in_range = {1'b0, addr_i} < ADDR_LIMIT;
    assign fault_o  = mem_access_fault(we_i, memop_i, addr_i[1:0], in_range);

endmodule

// File: rtl/lsu_dmem_port.sv
// Load/store initiator between the memory stage and dmem.
//   req_*  : valid/ready request (we, memop, addr, wdata)
//   resp_* : held valid/ready response (rdata, fault)
//   mem_*  : dmem addr/memop/datain/we, dataout back
// One transaction outstanding at a time. Every output is a register.
// Output registers are loaded from the current state, so they trail the
// state by one cycle: a store's write pulse lands the cycle after WR, and
// resp_valid rises the cycle after entering RESP.
module lsu_dmem_port
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_memop,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_memop,
    output logic [31:0]       mem_datain,
    output logic              mem_we,
    input  logic [31:0]       mem_dataout
);

    lsu_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]        mem_memop_q, mem_memop_d;
    logic [31:0]       mem_datain_q, mem_datain_d;
    logic              mem_we_q, mem_we_d;

    logic accept;
    logic req_fault;
    logic resp_done;

    lsu_align_check #(
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_align_check (
        .we_i    (req_we),
        .memop_i (req_memop),
        .addr_i  (req_addr),
        .fault_o (req_fault)
    );

    assign accept    = req_valid && req_ready_q;
    assign resp_done = resp_valid_q && resp_ready;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_memop_q  <= MEMOP_B;
            mem_datain_q <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            mem_addr_q   <= mem_addr_d;
            mem_memop_q  <= mem_memop_d;
            mem_datain_q <= mem_datain_d;
            mem_we_q     <= mem_we_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_fault)   state_d = ST_RESP;
                    else if (req_we) state_d = ST_WR;
                    else             state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: state_d = ST_RD_CAP;
            ST_RD_CAP:  state_d = ST_RESP;
            ST_WR:      state_d = ST_RESP;
            ST_RESP:    if (resp_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of the output registers
    always_comb begin
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_q == ST_RESP) && !resp_done;
        mem_we_d     = (state_q == ST_WR);
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        mem_addr_d   = mem_addr_q;
        mem_memop_d  = mem_memop_q;
        mem_datain_d = mem_datain_q;

        if (accept) begin
            resp_rdata_d = '0;
            resp_fault_d = req_fault;
            // Faulted requests never reach dmem, so the bus keeps its old values.
            if (!req_fault) begin
                mem_addr_d   = req_addr;
                mem_memop_d  = req_memop;
                mem_datain_d = req_wdata;
            end
        end

        // dmem produced dataout at the previous edge; take it now.
        if (state_q == ST_RD_CAP)
            resp_rdata_d = mem_dataout;
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign mem_addr   = mem_addr_q;
    assign mem_memop  = mem_memop_q;
    assign mem_datain = mem_datain_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Randomized self-checking bench for lsu_dmem_port with a behavioural dmem
// and an independent byte-array reference model.
module tb_lsu_dmem_port;

    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 2048;
    localparam int MEM_BYTES = 4 * MEM_WORDS;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_memop;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_memop;
    logic [31:0]       mem_datain;
    logic              mem_we;
    logic [31:0]       mem_dataout;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [7:0] dmem_bytes [MEM_BYTES];
    logic [7:0] ref_mem    [MEM_BYTES];

    lsu_dmem_port #(
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_memop   (req_memop),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .mem_addr    (mem_addr),
        .mem_memop   (mem_memop),
        .mem_datain  (mem_datain),
        .mem_we      (mem_we),
        .mem_dataout (mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dmem: synchronous read every edge, write when we.
    always @(posedge clk) begin
        int a;
        logic [7:0] b0, b1, b2, b3;
        a  = int'(mem_addr[12:0]);
        b0 = dmem_bytes[a];
        b1 = dmem_bytes[(a + 1) % MEM_BYTES];
        b2 = dmem_bytes[(a + 2) % MEM_BYTES];
        b3 = dmem_bytes[(a + 3) % MEM_BYTES];
        if (mem_we) begin
            dmem_bytes[a] <= mem_datain[7:0];
            if (mem_memop[1:0] != 2'b00) dmem_bytes[(a + 1) % MEM_BYTES] <= mem_datain[15:8];
            if (mem_memop[1:0] == 2'b10) begin
                dmem_bytes[(a + 2) % MEM_BYTES] <= mem_datain[23:16];
                dmem_bytes[(a + 3) % MEM_BYTES] <= mem_datain[31:24];
            end
        end
        case (mem_memop)
            3'b000:  mem_dataout <= {{24{b0[7]}}, b0};
            3'b001:  mem_dataout <= {{16{b1[7]}}, b1, b0};
            3'b100:  mem_dataout <= {24'd0, b0};
            3'b101:  mem_dataout <= {16'd0, b1, b0};
            default: mem_dataout <= {b3, b2, b1, b0};
        endcase
    end

    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic ref_fault(input logic we, input logic [2:0] op, input logic [31:0] addr);
        if (we && op > 3'd2) return 1'b1;
        if (!we && (op == 3'd3 || op == 3'd6 || op == 3'd7)) return 1'b1;
        if (addr >= 32'(MEM_BYTES)) return 1'b1;
        if (addr % 32'(op_size(op)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
        longint v;
        int n;
        n = op_size(op);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(addr) + i]) << (8 * i);
        if (op < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold, input logic poke);
        logic        exp_f;
        logic [31:0] exp_d;
        logic [31:0] r0;
        int          exp_lat, lat, n;
        exp_f   = ref_fault(we, op, addr);
        exp_d   = (we || exp_f) ? 32'd0 : ref_load(op, addr);
        exp_lat = exp_f ? 1 : (we ? 2 : 3);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_memop = op; req_addr = addr; req_wdata = wd;
        we_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("latency", lat, exp_lat);
        chk("resp_fault", resp_fault, exp_f);
        chk("resp_rdata", resp_rdata, exp_d);
        r0 = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b010;
                req_addr = 32'h100; req_wdata = 32'h5555_AAAA;
            end
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, r0);
            chk("hold_fault", resp_fault, exp_f);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk("mem_we_pulses", we_cnt, (we && !exp_f) ? 1 : 0);
        chk("resp_valid_drop", resp_valid, 0);
        chk("req_ready_back", req_ready, 1);
        if (we && !exp_f)
            for (int i = 0; i < op_size(op); i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_resp_fault"}, resp_fault, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_memop"}, 32'(mem_memop), 0);
        chk({tag, "_mem_datain"}, mem_datain, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [2:0]  op;
        logic        we;
        int          n;
        for (int i = 0; i < MEM_BYTES; i++) begin
            dmem_bytes[i] = 8'($urandom);
            ref_mem[i]    = dmem_bytes[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_memop = 3'b000;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);
        chk("lw_dead", resp_rdata, 32'hDEAD_BEEF);
        do_req(1'b1, 3'b000, 32'h20, 32'h0000_0080, 0, 1'b0);
        do_req(1'b0, 3'b000, 32'h20, 32'h0, 0, 1'b0);
        chk("lb_sext", resp_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h20, 32'h0, 0, 1'b0);
        chk("lbu_zext", resp_rdata, 32'h0000_0080);
        do_req(1'b0, 3'b001, 32'h21, 32'h0, 0, 1'b0);
        chk("lh_odd_fault", resp_fault, 1);
        do_req(1'b1, 3'b010, 32'h22, 32'h1234_5678, 0, 1'b0);
        chk("sw_mis_fault", resp_fault, 1);
        do_req(1'b0, 3'b010, 32'h2000, 32'h0, 0, 1'b0);
        chk("lw_oor_fault", resp_fault, 1);

        // Held response with a competing request that must not be taken
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, 1'b1);
        @(negedge clk);
        chk("poke_not_taken_addr", mem_addr, 32'h10);
        chk("poke_not_taken_ready", req_ready, 1);

        // Reset while the write pulse is up: no write, everything back to reset
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b010; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("wr_pulse_up", mem_we, 1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_wr");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 0, 1'b0);

        // Illegal store memop must not write
        do_req(1'b1, 3'b100, 32'h10, 32'h0BAD_0BAD, 0, 1'b0);
        chk("sbu_fault", resp_fault, 1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1, 1'b0);
        chk("lw_prior", resp_rdata, 32'hDEAD_BEEF);

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 32'h2000 + 32'($urandom_range(0, 4095));
            else a = 32'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 2) != 0) a = a & ~32'(op_size(op) - 1);
            if ($urandom_range(0, 3) == 0) a = a % 32'h80;
            wd = $urandom;
            do_req(we, op, a, wd, $urandom_range(0, 2), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
